rx_tlp_classifier: RTL and testbench

- Sits directly upstream of the VC0 receive buffer set (PH, PD, NPH, NPD, CH, CD buffers).
- Accepts an 8-bit TLP byte stream from the data link layer and decodes Fmt/Type from header byte 0.
- Steers header bytes to the class header buffer and payload bytes to the class data buffer; drops malformed or unsupported TLPs.
- Flags errors and drives backpressure from the six buffer full flags.

---
 rtl/rx_tlp_classifier_if.sv | 14 +
 rtl/rx_tlp_classifier.sv | 241 ++++++++++++++++++++++++
 tb/tb_rx_tlp_classifier.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_tlp_classifier_if.sv
// TLP byte stream from the data link layer into the VC0 receive classifier.
// The master modport is the byte source; the slave modport is the classifier.
interface rx_tlp_classifier_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, in_sop, in_eop, in_data, input in_ready);
    modport slave  (input in_valid, in_sop, in_eop, in_data, output in_ready);
endinterface

// File: rtl/rx_tlp_classifier.sv
// Steers received TLP bytes into the VC0 PH/PD/NPH/NPD/CH/CD buffers and drops bad TLPs.
// Define RX_FC_CREDIT_CNT_EN to add the received-credit counter outputs.
module rx_tlp_classifier #(
    parameter int DATA_WIDTH        = 8,   // only 8 is supported
    parameter int MAX_PAYLOAD_BYTES = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    rx_tlp_classifier_if.slave    s_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ph_wr_en,
    output logic                  pd_wr_en,
    output logic                  nph_wr_en,
    output logic                  npd_wr_en,
    output logic                  ch_wr_en,
    output logic                  cd_wr_en,
    input  logic                  ph_full,
    input  logic                  pd_full,
    input  logic                  nph_full,
    input  logic                  npd_full,
    input  logic                  ch_full,
    input  logic                  cd_full,
    output logic                  err_unsup,
    output logic                  err_len,
    output logic                  err_framing,
    output logic                  busy
`ifdef RX_FC_CREDIT_CNT_EN
    ,
    output logic [7:0]            ph_cr_rcvd,
    output logic [7:0]            nph_cr_rcvd,
    output logic [7:0]            ch_cr_rcvd,
    output logic [11:0]           pd_cr_rcvd,
    output logic [11:0]           npd_cr_rcvd,
    output logic [11:0]           cd_cr_rcvd
`endif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [1:0] CLS_P  = 2'd0;
    localparam logic [1:0] CLS_NP = 2'd1;
    localparam logic [1:0] CLS_C  = 2'd2;

    localparam logic [13:0] MAX_PL = 14'(MAX_PAYLOAD_BYTES);

    logic [1:0]  r_state, w_state_next;
    logic [1:0]  r_cls, w_cls_next;
    logic        r_has_data, w_has_data_next;
    logic        r_hdr4dw, w_hdr4dw_next;
    logic [4:0]  r_hdr_cnt, w_hdr_cnt_next;
    logic [12:0] r_data_cnt, w_data_cnt_next;
    logic [9:0]  r_len, w_len_next;

    logic        w_dec_ok;
    logic [1:0]  w_dec_cls;
    logic [5:0]  w_tgt, w_full, w_wr;
    logic        w_accept, w_done;
    logic        w_err_unsup, w_err_len, w_err_framing;
    logic [4:0]  w_hdr_last_idx;
    logic [10:0] w_len_dw;
    logic [12:0] w_payload;
    logic        w_oversize;

    // Fmt/Type decode of the byte currently on the bus (only meaningful on a sop byte).
    always_comb begin
        w_dec_ok  = 1'b0;
        w_dec_cls = CLS_P;
        if (s_in.in_data[4:0] == 5'h00) begin
            w_dec_ok  = !s_in.in_data[7];
            w_dec_cls = s_in.in_data[6] ? CLS_P : CLS_NP;
        end else if (s_in.in_data[4:0] == 5'h02 || s_in.in_data[4:0] == 5'h04 ||
                     s_in.in_data[4:0] == 5'h05) begin
            w_dec_ok  = (s_in.in_data[7:5] == 3'd0) || (s_in.in_data[7:5] == 3'd2);
            w_dec_cls = CLS_NP;
        end else if (s_in.in_data[4:3] == 2'b10) begin
            w_dec_ok  = (s_in.in_data[7:5] == 3'd1) || (s_in.in_data[7:5] == 3'd3);
            w_dec_cls = CLS_P;
        end else if (s_in.in_data[4:0] == 5'h0A) begin
            w_dec_ok  = (s_in.in_data[7:5] == 3'd0) || (s_in.in_data[7:5] == 3'd2);
            w_dec_cls = CLS_C;
        end
    end

    // Buffer index: 2*class for the header buffer, 2*class+1 for the data buffer.
    always_comb begin
        w_tgt = 6'b0;
        if (s_in.in_sop) begin
            if (w_dec_ok) w_tgt = 6'b000001 << {w_dec_cls, 1'b0};
        end else if (r_state == ST_HDR) begin
            w_tgt = 6'b000001 << {r_cls, 1'b0};
        end else if (r_state == ST_DATA) begin
            w_tgt = 6'b000010 << {r_cls, 1'b0};
        end
    end

    assign w_full        = {cd_full, ch_full, npd_full, nph_full, pd_full, ph_full};
    assign s_in.in_ready = !rst && ((w_tgt & w_full) == 6'b0);
    assign w_accept      = s_in.in_valid && s_in.in_ready;
    assign out_data      = s_in.in_data;

    for (genvar gi = 0; gi < 6; gi++) begin : g_wr
        assign w_wr[gi] = w_accept && w_tgt[gi];
    end
    assign {cd_wr_en, ch_wr_en, npd_wr_en, nph_wr_en, pd_wr_en, ph_wr_en} = w_wr;

    assign w_hdr_last_idx = r_hdr4dw ? 5'd15 : 5'd11;
    assign w_len_dw       = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
    assign w_payload      = {w_len_dw, 2'b00};
    assign w_oversize     = {1'b0, w_payload} > MAX_PL;

    always_comb begin
        w_state_next    = r_state;
        w_cls_next      = r_cls;
        w_has_data_next = r_has_data;
        w_hdr4dw_next   = r_hdr4dw;
        w_hdr_cnt_next  = r_hdr_cnt;
        w_data_cnt_next = r_data_cnt;
        w_len_next      = r_len;
        w_err_unsup     = 1'b0;
        w_err_len       = 1'b0;
        w_err_framing   = 1'b0;
        w_done          = 1'b0;
        if (w_accept) begin
            if (s_in.in_sop) begin
                // A sop always restarts decoding, abandoning whatever was in flight.
                w_err_framing   = (r_state != ST_IDLE);
                w_cls_next      = w_dec_cls;
                w_has_data_next = s_in.in_data[6];
                w_hdr4dw_next   = s_in.in_data[5];
                w_hdr_cnt_next  = 5'd1;
                w_len_next      = 10'd0;
                if (!w_dec_ok) begin
                    w_err_unsup  = 1'b1;
                    w_state_next = s_in.in_eop ? ST_IDLE : ST_DROP;
                end else if (s_in.in_eop) begin
                    w_err_len    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_HDR;
                end
            end else begin
                case (r_state)
                    ST_IDLE: w_err_framing = 1'b1;
                    ST_HDR: begin
                        w_hdr_cnt_next = r_hdr_cnt + 5'd1;
                        if (r_hdr_cnt == 5'd2) w_len_next[9:8] = s_in.in_data[1:0];
                        if (r_hdr_cnt == 5'd3) w_len_next[7:0] = s_in.in_data[7:0];
                        if (r_hdr_cnt == w_hdr_last_idx) begin
                            if (!r_has_data) begin
                                w_done       = s_in.in_eop;
                                w_err_len    = !s_in.in_eop;
                                w_state_next = s_in.in_eop ? ST_IDLE : ST_DROP;
                            end else if (s_in.in_eop || w_oversize) begin
                                w_err_len    = 1'b1;
                                w_state_next = s_in.in_eop ? ST_IDLE : ST_DROP;
                            end else begin
                                w_state_next    = ST_DATA;
                                w_data_cnt_next = w_payload;
                            end
                        end else if (s_in.in_eop) begin
                            w_err_len    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        w_data_cnt_next = r_data_cnt - 13'd1;
                        if (r_data_cnt == 13'd1) begin
                            w_done       = s_in.in_eop;
                            w_err_len    = !s_in.in_eop;
                            w_state_next = s_in.in_eop ? ST_IDLE : ST_DROP;
                        end else if (s_in.in_eop) begin
                            w_err_len    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: if (s_in.in_eop) w_state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cls      <= CLS_P;
            r_has_data <= 1'b0;
            r_hdr4dw   <= 1'b0;
            r_hdr_cnt  <= 5'd0;
            r_data_cnt <= 13'd0;
            r_len      <= 10'd0;
        end else begin
            r_state    <= w_state_next;
            r_cls      <= w_cls_next;
            r_has_data <= w_has_data_next;
            r_hdr4dw   <= w_hdr4dw_next;
            r_hdr_cnt  <= w_hdr_cnt_next;
            r_data_cnt <= w_data_cnt_next;
            r_len      <= w_len_next;
        end
    end

    assign err_unsup   = w_err_unsup;
    assign err_len     = w_err_len;
    assign err_framing = w_err_framing;
    assign busy        = (r_state != ST_IDLE);

`ifdef RX_FC_CREDIT_CNT_EN
    logic [10:0] w_len_dw_p3;
    logic [8:0]  w_data_cr;
    assign w_len_dw_p3 = w_len_dw + 11'd3;
    assign w_data_cr   = w_len_dw_p3[10:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cr_rcvd  <= 8'd0;
            nph_cr_rcvd <= 8'd0;
            ch_cr_rcvd  <= 8'd0;
            pd_cr_rcvd  <= 12'd0;
            npd_cr_rcvd <= 12'd0;
            cd_cr_rcvd  <= 12'd0;
        end else if (w_done) begin
            case (r_cls)
                CLS_P: begin
                    ph_cr_rcvd <= ph_cr_rcvd + 8'd1;
                    if (r_has_data) pd_cr_rcvd <= pd_cr_rcvd + {3'b0, w_data_cr};
                end
                CLS_NP: begin
                    nph_cr_rcvd <= nph_cr_rcvd + 8'd1;
                    if (r_has_data) npd_cr_rcvd <= npd_cr_rcvd + {3'b0, w_data_cr};
                end
                default: begin
                    ch_cr_rcvd <= ch_cr_rcvd + 8'd1;
                    if (r_has_data) cd_cr_rcvd <= cd_cr_rcvd + {3'b0, w_data_cr};
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_rx_tlp_classifier.sv
// Directed bench for rx_tlp_classifier: a TLP-level vector table plus hand-written corner sequences.
module tb_rx_tlp_classifier;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_tlp_classifier_if #(.DATA_WIDTH(8)) bus ();

    logic [5:0] full_v;
    logic [7:0] out_data;
    logic ph_wr_en, pd_wr_en, nph_wr_en, npd_wr_en, ch_wr_en, cd_wr_en;
    logic err_unsup, err_len, err_framing, busy;
`ifdef RX_FC_CREDIT_CNT_EN
    logic [7:0]  ph_cr_rcvd, nph_cr_rcvd, ch_cr_rcvd;
    logic [11:0] pd_cr_rcvd, npd_cr_rcvd, cd_cr_rcvd;
`endif

    rx_tlp_classifier #(.DATA_WIDTH(8), .MAX_PAYLOAD_BYTES(512)) dut (
        .clk(clk), .rst(rst), .s_in(bus), .out_data(out_data),
        .ph_wr_en(ph_wr_en), .pd_wr_en(pd_wr_en), .nph_wr_en(nph_wr_en),
        .npd_wr_en(npd_wr_en), .ch_wr_en(ch_wr_en), .cd_wr_en(cd_wr_en),
        .ph_full(full_v[0]), .pd_full(full_v[1]), .nph_full(full_v[2]),
        .npd_full(full_v[3]), .ch_full(full_v[4]), .cd_full(full_v[5]),
        .err_unsup(err_unsup), .err_len(err_len), .err_framing(err_framing), .busy(busy)
`ifdef RX_FC_CREDIT_CNT_EN
        ,
        .ph_cr_rcvd(ph_cr_rcvd), .nph_cr_rcvd(nph_cr_rcvd), .ch_cr_rcvd(ch_cr_rcvd),
        .pd_cr_rcvd(pd_cr_rcvd), .npd_cr_rcvd(npd_cr_rcvd), .cd_cr_rcvd(cd_cr_rcvd)
`endif
    );

    wire [5:0] wr_vec = {cd_wr_en, ch_wr_en, npd_wr_en, nph_wr_en, pd_wr_en, ph_wr_en};

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_wr[6];
    int cnt_unsup, cnt_len, cnt_frm;
    logic [5:0] last_wr;
    logic last_ready, last_frm;

    typedef struct {
        logic [7:0] b0;
        logic [9:0] len;
        int nbytes;
        int stall_at;
        int stall_n;
        int hidx;
        int exp_h;
        int exp_d;
        int exp_unsup;
        int exp_len;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [7:0] b0, input logic [9:0] len, input int nb,
                                input int sa, input int sn, input int hidx, input int eh,
                                input int ed, input int eu, input int el);
        vec_t v;
        v.b0 = b0; v.len = len; v.nbytes = nb; v.stall_at = sa; v.stall_n = sn;
        v.hidx = hidx; v.exp_h = eh; v.exp_d = ed; v.exp_unsup = eu; v.exp_len = el;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input int i, input logic [7:0] b0, input logic [9:0] len);
        if (i == 0) return b0;
        if (i == 2) return {6'b0, len[9:8]};
        if (i == 3) return len[7:0];
        return 8'(i * 7 + 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 6; k++) cnt_wr[k] = 0;
        cnt_unsup = 0; cnt_len = 0; cnt_frm = 0;
    endtask

    task automatic drive_byte(input logic s, input logic e, input logic [7:0] d, output logic acc);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sop = s; bus.in_eop = e; bus.in_data = d;
        #2;
        for (int k = 0; k < 6; k++) cnt_wr[k] += int'(wr_vec[k]);
        cnt_unsup += int'(err_unsup);
        cnt_len   += int'(err_len);
        cnt_frm   += int'(err_framing);
        last_wr    = wr_vec;
        last_ready = bus.in_ready;
        last_frm   = err_framing;
        acc        = bus.in_ready;
    endtask

    task automatic send_byte(input logic s, input logic e, input logic [7:0] d);
        logic acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 50) begin
            drive_byte(s, e, d, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        #2;
    endtask

    task automatic send_tlp(input logic [7:0] b0, input logic [9:0] len, input int nb,
                            input int sa, input int sn, input int hidx);
        logic acc;
        for (int i = 0; i < nb; i++) begin
            if (i == sa) begin
                full_v[hidx] = 1'b1;
                for (int s = 0; s < sn; s++) begin
                    drive_byte(i == 0, i == nb - 1, byte_of(i, b0, len), acc);
                    chk("stall_ready", int'(last_ready), 0);
                end
                full_v = 6'b0;
            end
            send_byte(i == 0, i == nb - 1, byte_of(i, b0, len));
        end
    endtask

    logic acc_d;
    int exp_cnt;

    initial begin
        #5000000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1);
    end

    initial begin
        // b0, len, nbytes, stall_at, stall_n, hdr buffer idx, exp hdr wr, exp data wr, unsup, len
        vecs[0]  = mk(8'h40, 10'd1,   16,  -1, 0, 0, 12, 4,   0, 0); // MWr 3DW len 1
        vecs[1]  = mk(8'h20, 10'd1,   16,   5, 3, 2, 16, 0,   0, 0); // MRd 4DW, nph_full stall
        vecs[2]  = mk(8'h4A, 10'd2,   17,  -1, 0, 4, 12, 5,   0, 1); // CplD early eop
        vecs[3]  = mk(8'h7F, 10'd1,   16,  -1, 0, 0, 0,  0,   1, 0); // unsupported
        vecs[4]  = mk(8'h00, 10'd1,   8,   -1, 0, 2, 8,  0,   0, 1); // MRd eop mid-header
        vecs[5]  = mk(8'h0A, 10'd0,   12,  -1, 0, 4, 12, 0,   0, 0); // Cpl no data
        vecs[6]  = mk(8'h40, 10'd129, 14,  -1, 0, 0, 12, 0,   0, 1); // oversize 516 bytes
        vecs[7]  = mk(8'h40, 10'd128, 524, -1, 0, 0, 12, 512, 0, 0); // exactly max payload
        vecs[8]  = mk(8'h60, 10'd0,   17,  -1, 0, 0, 16, 0,   0, 1); // Length 0 = 4096 bytes
        vecs[9]  = mk(8'h00, 10'd1,   14,  -1, 0, 2, 12, 0,   0, 1); // MRd missing eop
        vecs[10] = mk(8'h70, 10'd1,   20,  -1, 0, 0, 16, 4,   0, 0); // MsgD
        vecs[11] = mk(8'h44, 10'd1,   16,  -1, 0, 2, 12, 4,   0, 0); // CfgWr
        vecs[12] = mk(8'h40, 10'd1,   18,  -1, 0, 0, 12, 4,   0, 1); // payload runs past length
        vecs[13] = mk(8'h33, 10'd0,   16,  -1, 0, 0, 16, 0,   0, 0); // Msg 4DW

        rst = 1'b1; full_v = 6'b0;
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(posedge clk);
        clear_counts();
        drive_byte(1'b1, 1'b0, 8'h40, acc_d);
        $display("reset: in_ready=%0d wr=%b busy=%0d", last_ready, last_wr, busy);
        chk("rst_ready", int'(last_ready), 0);
        chk("rst_wr", int'(last_wr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_errs", int'({err_unsup, err_len, err_framing}), 0);
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        idle();

        for (int i = 0; i < 14; i++) begin
            clear_counts();
            send_tlp(vecs[i].b0, vecs[i].len, vecs[i].nbytes, vecs[i].stall_at,
                     vecs[i].stall_n, vecs[i].hidx);
            idle();
            $display("vec %0d: b0=%h wr=%0d/%0d/%0d/%0d/%0d/%0d unsup=%0d len=%0d frm=%0d busy=%0d",
                     i, vecs[i].b0, cnt_wr[0], cnt_wr[1], cnt_wr[2], cnt_wr[3], cnt_wr[4],
                     cnt_wr[5], cnt_unsup, cnt_len, cnt_frm, busy);
            for (int k = 0; k < 6; k++) begin
                exp_cnt = (k == vecs[i].hidx) ? vecs[i].exp_h :
                          (k == vecs[i].hidx + 1) ? vecs[i].exp_d : 0;
                chk($sformatf("vec%0d_wr%0d", i, k), cnt_wr[k], exp_cnt);
            end
            chk($sformatf("vec%0d_unsup", i), cnt_unsup, vecs[i].exp_unsup);
            chk($sformatf("vec%0d_len", i), cnt_len, vecs[i].exp_len);
            chk($sformatf("vec%0d_framing", i), cnt_frm, 0);
            chk($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // Unsupported TLP keeps busy high until its eop, with in_ready held high.
        clear_counts();
        send_byte(1'b1, 1'b0, 8'h7F);
        idle();
        chk("unsup_busy_mid", int'(busy), 1);
        drive_byte(1'b0, 1'b0, 8'h55, acc_d);
        chk("unsup_ready_mid", int'(last_ready), 1);
        send_byte(1'b0, 1'b1, 8'h66);
        idle();
        $display("unsup seq: busy=%0d unsup=%0d", busy, cnt_unsup);
        chk("unsup_busy_end", int'(busy), 0);

        // Non-sop byte in IDLE is a framing error and is discarded.
        clear_counts();
        drive_byte(1'b0, 1'b0, 8'h40, acc_d);
        $display("idle non-sop: frm=%0d wr=%b ready=%0d", last_frm, last_wr, last_ready);
        chk("idle_nonsop_frm", int'(last_frm), 1);
        chk("idle_nonsop_wr", int'(last_wr), 0);
        chk("idle_nonsop_ready", int'(last_ready), 1);
        idle();
        chk("idle_nonsop_busy", int'(busy), 0);

        // sop mid-payload of a MWr restarts on the new TLP in the same cycle.
        clear_counts();
        for (int i = 0; i < 15; i++) send_byte(i == 0, 1'b0, byte_of(i, 8'h40, 10'd2));
        drive_byte(1'b1, 1'b0, 8'h0A, acc_d);
        $display("midsop: frm=%0d wr=%b out_data=%h", last_frm, last_wr, out_data);
        chk("midsop_frm", int'(last_frm), 1);
        chk("midsop_wr", int'(last_wr), 16);
        chk("midsop_out_data", int'(out_data), 8'h0A);
        for (int i = 1; i < 12; i++) send_byte(1'b0, i == 11, byte_of(i, 8'h0A, 10'd0));
        idle();
        chk("midsop_ph", cnt_wr[0], 12);
        chk("midsop_pd", cnt_wr[1], 3);
        chk("midsop_ch", cnt_wr[4], 12);
        chk("midsop_frm_total", cnt_frm, 1);
        chk("midsop_len", cnt_len, 0);
        chk("midsop_busy", int'(busy), 0);

        // Reset in the middle of a TLP returns to IDLE.
        clear_counts();
        for (int i = 0; i < 5; i++) send_byte(i == 0, 1'b0, byte_of(i, 8'h40, 10'd1));
        idle();
        chk("midrst_busy_before", int'(busy), 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle();
        $display("midrst: busy=%0d", busy);
        chk("midrst_busy_after", int'(busy), 0);

`ifdef RX_FC_CREDIT_CNT_EN
        begin
            logic [7:0]  ph0;
            logic [11:0] pd0;
            ph0 = ph_cr_rcvd; pd0 = pd_cr_rcvd;
            send_tlp(8'h40, 10'd5, 32, -1, 0, 0);
            send_tlp(8'h40, 10'd5, 32, -1, 0, 0);
            idle();
            $display("credits: ph=%0d pd=%0d", ph_cr_rcvd - ph0, pd_cr_rcvd - pd0);
            chk("cr_ph", int'(8'(ph_cr_rcvd - ph0)), 2);
            chk("cr_pd", int'(12'(pd_cr_rcvd - pd0)), 4);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
